// File: rtl/transaction_arbiter.sv
// transaction_arbiter: round-robin sharing of the single transaction sequencer
// among NUM_REQ requesters, with a watchdog that aborts stalled transactions.
module transaction_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         step,
    input  logic               done_step,
    output logic               start_transaction,
    output logic               ctrl_resetn,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] err,
    output logic               busy
);

    localparam int unsigned IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0]  STEP_FINISH = 3'b100;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   wd_cnt_q;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   rr_cand;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_next;
    logic               complete;
    logic               wd_expired;
    logic [NUM_REQ-1:0] clr;

    // Round-robin search of the pending set starting at rr_ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        rr_cand  = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_cand = IDX_W'(rr_ptr_q + IDX_W'(k));
            if (!rr_found && pending_q[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Index of the current owner; the served requester is searched last next time.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
        rr_next = IDX_W'(grant_idx + IDX_W'(1));
    end

    // End-of-transaction detection; completion takes precedence over the watchdog.
    always_comb begin
        complete   = (state_q == ST_WAIT) && (step == STEP_FINISH) && done_step;
        wd_expired = (state_q == ST_WAIT) && (wd_cnt_q == WD_LAST);
        clr        = (complete || wd_expired) ? grant_q : '0;
        pending_d  = (pending_q & ~clr) | req;
    end

    // Arbitration FSM with pending latch, owner, pointer and watchdog counter.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            wd_cnt_q  <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_q <= NUM_REQ'(1) << rr_idx;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt_q <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (complete) begin
                        rr_ptr_q <= rr_next;
                        state_q  <= ST_DONE;
                    end else if (wd_expired) begin
                        rr_ptr_q <= rr_next;
                        state_q  <= ST_ABORT;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE, ST_ABORT: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode straight from registered state.
    always_comb begin
        start_transaction = (state_q == ST_ISSUE);
        busy              = (state_q != ST_IDLE);
        ctrl_resetn       = resetn && (state_q != ST_ABORT);
        grant             = grant_q;
        pending           = pending_q;
        ack               = (state_q == ST_DONE)  ? grant_q : '0;
        err               = (state_q == ST_ABORT) ? grant_q : '0;
    end

endmodule

// File: tb/tb_transaction_arbiter.sv
// Bench for transaction_arbiter: directed table, corner-case sequences and
// randomized traffic against a transaction-timeline reference model.
module tb_transaction_arbiter;

    localparam int TO = 8;

    logic       clock;
    logic       resetn;
    logic [3:0] req;
    logic [2:0] step;
    logic       done_step;
    logic       start_transaction;
    logic       ctrl_resetn;
    logic [3:0] grant;
    logic [3:0] pending;
    logic [3:0] ack;
    logic [3:0] err;
    logic       busy;

    transaction_arbiter #(
        .NUM_REQ(4),
        .TIMEOUT(TO),
        .CNT_W  (16)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .req              (req),
        .step             (step),
        .done_step        (done_step),
        .start_transaction(start_transaction),
        .ctrl_resetn      (ctrl_resetn),
        .grant            (grant),
        .pending          (pending),
        .ack              (ack),
        .err              (err),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: one transaction at a time, described by its owner, the
    // cycle it was issued and the cycle its ack/err pulse appears.
    int         cyc_n   = 0;
    int         m_owner = -1;
    int         m_issue = 0;
    int         m_end   = -1;
    bit         m_err   = 1'b0;
    int         m_rr    = 0;
    logic [3:0] m_pend  = 4'b0;

    typedef struct packed {
        logic [3:0] req;
        logic [2:0] stp;
        logic       dn;
        logic [3:0] g;
        logic [3:0] p;
        logic       s;
        logic [3:0] a;
        logic       b;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs of the ending cycle.
    task automatic model_edge();
        int         prev;
        bit         was_idle;
        logic [3:0] pend_prev;
        logic [3:0] clr;
        int         idx;
        prev      = cyc_n;
        cyc_n     = cyc_n + 1;
        was_idle  = (m_owner < 0);
        pend_prev = m_pend;
        clr       = 4'b0;
        if (!resetn) begin
            m_pend  = 4'b0;
            m_owner = -1;
            m_end   = -1;
            m_rr    = 0;
        end else begin
            if (m_owner >= 0) begin
                if (m_end >= 0 && prev == m_end) begin
                    m_owner = -1;
                end else if (m_end < 0 && prev > m_issue) begin
                    if (step == 3'd4 && done_step) begin
                        m_end = cyc_n;
                        m_err = 1'b0;
                    end else if (prev == m_issue + TO) begin
                        m_end = cyc_n;
                        m_err = 1'b1;
                    end
                    if (m_end >= 0) begin
                        clr[m_owner] = 1'b1;
                        m_rr = (m_owner + 1) % 4;
                    end
                end
            end
            m_pend = (m_pend & ~clr) | req;
            if (was_idle && pend_prev != 4'b0) begin
                for (int k = 3; k >= 0; k--) begin
                    idx = (m_rr + k) % 4;
                    if (pend_prev[idx]) m_owner = idx;
                end
                m_issue = cyc_n;
                m_end   = -1;
            end
        end
    endtask

    task automatic model_check();
        logic [3:0] eg;
        bit         in_end;
        eg     = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        in_end = (m_owner >= 0) && (m_end == cyc_n);
        chk("grant",   32'(grant),             32'(eg));
        chk("pending", 32'(pending),           32'(m_pend));
        chk("start",   32'(start_transaction), 32'((m_owner >= 0) && (cyc_n == m_issue)));
        chk("busy",    32'(busy),              32'(m_owner >= 0));
        chk("ack",     32'(ack),               32'((in_end && !m_err) ? eg : 4'b0));
        chk("err",     32'(err),               32'((in_end && m_err) ? eg : 4'b0));
        chk("ctrl_resetn", 32'(ctrl_resetn),   32'(resetn && !(in_end && m_err)));
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cyc(input logic [3:0] r, input logic [2:0] s, input logic d, input logic rn);
        req       = r;
        step      = s;
        done_step = d;
        resetn    = rn;
        @(posedge clock);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        cyc(4'b0, 3'd0, 1'b0, 1'b0);
        cyc(4'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int         start_c;
        int         err_c;
        int         low_cnt;
        int         acks;
        int         n_gr;
        bit         seen;
        logic [3:0] order [4];
        logic [3:0] regrant;
        logic [3:0] ack_or;
        logic [3:0] r;

        req = 4'b0; step = 3'd0; done_step = 1'b0; resetn = 1'b0;

        // Reset state
        do_reset();
        chk("reset_outputs", {grant, pending, ack, err, start_transaction, busy, ctrl_resetn}, 32'd0);

        // Directed single request, late completion coinciding with the watchdog limit
        for (int i = 0; i < 13; i++)
            tbl[i] = '{req: 4'b0, stp: 3'd0, dn: 1'b0, g: 4'b0100, p: 4'b0100, s: 1'b0, a: 4'b0, b: 1'b1};
        tbl[0].req = 4'b0100; tbl[0].g = 4'b0; tbl[0].b = 1'b0;
        tbl[1].s   = 1'b1;
        tbl[9].stp = 3'd3;  tbl[9].dn = 1'b1;
        tbl[10].stp = 3'd4; tbl[10].dn = 1'b1; tbl[10].a = 4'b0100; tbl[10].p = 4'b0;
        for (int i = 11; i < 13; i++) begin
            tbl[i].g = 4'b0; tbl[i].p = 4'b0; tbl[i].b = 1'b0;
        end
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].req, tbl[i].stp, tbl[i].dn, 1'b1);
            chk($sformatf("tbl%0d", i),
                {grant, pending, start_transaction, ack, busy, err},
                32'({tbl[i].g, tbl[i].p, tbl[i].s, tbl[i].a, tbl[i].b, 4'b0}));
        end

        // Round-robin with all four requesting at once
        do_reset();
        cyc(4'b1111, 3'd0, 1'b0, 1'b1);
        n_gr = 0; acks = 0;
        for (int i = 0; i < 80 && !(n_gr == 4 && !busy); i++) begin
            if (start_transaction && n_gr < 4) begin
                order[n_gr] = grant;
                n_gr++;
            end
            if (ack != 4'b0) acks++;
            if (m_owner >= 0 && m_end < 0 && cyc_n == m_issue + 5) cyc(4'b0, 3'd4, 1'b1, 1'b1);
            else cyc(4'b0, 3'd0, 1'b0, 1'b1);
        end
        chk("rr_count", 32'(n_gr), 32'd4);
        chk("rr_acks",  32'(acks), 32'd4);
        chk("rr_order", {16'd0, order[0], order[1], order[2], order[3]}, 32'h1248);
        chk("rr_idle",  32'(busy), 32'd0);

        // Watchdog: never complete
        do_reset();
        cyc(4'b0001, 3'd0, 1'b0, 1'b1);
        start_c = -1; err_c = -1; low_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(4'b0, 3'd0, 1'b0, 1'b1);
            if (start_transaction) start_c = cyc_n;
            if (err != 4'b0) begin
                err_c = cyc_n;
                chk("wd_err_val", 32'(err), 32'b0001);
            end
            if (!ctrl_resetn) low_cnt++;
            if (ack != 4'b0) seen = 1'b1;
        end
        chk("wd_err_cycle", 32'(err_c - start_c), 32'(TO + 1));
        chk("wd_ctrl_low",  32'(low_cnt), 32'd1);
        chk("wd_no_ack",    32'(seen), 32'd0);
        chk("wd_pend_clr",  32'(pending), 32'd0);

        // Set wins over clear on the completion edge
        do_reset();
        cyc(4'b0010, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(4'b0, 3'd0, 1'b0, 1'b1);
        cyc(4'b0010, 3'd4, 1'b1, 1'b1);
        chk("sw_ack",  32'(ack), 32'b0010);
        chk("sw_pend", 32'(pending), 32'b0010);
        regrant = 4'b0;
        for (int i = 0; i < 6 && regrant == 4'b0; i++) begin
            cyc(4'b0, 3'd0, 1'b0, 1'b1);
            if (start_transaction) regrant = grant;
        end
        chk("sw_regrant", 32'(regrant), 32'b0010);

        // Reset in the middle of a transaction
        do_reset();
        cyc(4'b1010, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(4'b0, 3'd0, 1'b0, 1'b1);
        chk("mr_pend_before", 32'(pending), 32'b1010);
        cyc(4'b0, 3'd4, 1'b1, 1'b0);
        chk("mr_outputs", {grant, pending, ack, err, start_transaction, busy, ctrl_resetn}, 32'd0);
        ack_or = 4'b0;
        for (int i = 0; i < TO + 6; i++) begin
            cyc(4'b0, 3'd4, 1'b1, 1'b1);
            ack_or = ack_or | ack | err;
        end
        chk("mr_no_ack_err", 32'(ack_or), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            cyc(r,
                ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 299) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
